ram: RTL and testbench
======================

RAM -- requirements
Module: ram

Interface
REQ-001 The module SHALL have parameter ADDR_BITS, default 4, which is the address width; depth is 2**ADDR_BITS words.
REQ-002 The module SHALL have parameter DATA_BITS, default 8, which is the word width.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all storage updates occur on its rising edge.
REQ-004 The module SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port address, input, ADDR_BITS bits: the word select for both read and write.
REQ-006 The module SHALL have port data, inout, DATA_BITS bits: a bidirectional data bus, driven by the RAM on reads and by the external master on writes.
REQ-007 The module SHALL have port out_en, input, 1 bit: read enable; while high, the RAM drives the bus.
REQ-008 The module SHALL have port write_en, input, 1 bit: write enable; while high, the bus is sampled into memory.
REQ-009 The module SHALL have port parity_err, output, 1 bit: read parity mismatch; this port is present only with RAM_PARITY_EN.

Function
REQ-010 Write: at the rising edge of clk with write_en=1 and reset_n=1, mem[address] SHALL take the value on data; the new value SHALL be visible to a read in the next cycle.
REQ-011 Read: while out_en=1 and write_en=0, data SHALL be driven combinationally with mem[address], with zero-cycle latency from a change of address.
REQ-012 While out_en=0, write_en=1, or reset_n=0, the RAM SHALL drive data to high-impedance on all bits.
REQ-013 With out_en=1 and write_en=1 together, the write SHALL take priority: the bus is not driven by the RAM and the write completes as in REQ-010.
REQ-014 An address change in the same cycle as write_en SHALL write only the address sampled at the clock edge; no other word is modified.
REQ-015 Every address 0 through 2**ADDR_BITS-1 SHALL be valid; there is no wrap and no out-of-range condition.
REQ-016 Unknown or high-impedance bits on data during a write SHALL be stored as-is; no checking is performed.

Reset
REQ-017 reset_n=0 SHALL asynchronously clear every memory word to 0; writes are ignored while reset is asserted.
REQ-018 A reset asserted mid-write SHALL abort the write, and the addressed word SHALL read 0 after reset.
REQ-019 After reset release, the first rising edge of clk SHALL be able to perform a write.
REQ-020 parity_err SHALL be 0 while reset is asserted and immediately after reset release.

Configuration
REQ-021 With macro RAM_PARITY_EN defined, each word SHALL store one additional even-parity bit computed on write.
REQ-022 With RAM_PARITY_EN defined, parity_err SHALL be high combinationally during a read (REQ-011) when the stored parity does not match the recomputed parity, and 0 otherwise.
REQ-023 With RAM_PARITY_EN defined, reset SHALL clear the parity bits to 0, which is consistent with zero data.
REQ-024 Without RAM_PARITY_EN, there SHALL be no parity storage and no parity_err port; all other behaviour is identical.

Structure
REQ-025 Package ram_pkg SHALL hold the default ADDR_BITS and DATA_BITS constants and the parity function.
REQ-026 Parity generation and checking SHALL be placed in sub-module ram_parity, instantiated only under RAM_PARITY_EN.
REQ-027 The tri-state driver SHALL be a single continuous assignment on data; there SHALL be no other drivers of data inside the RAM.

Verification
REQ-028 Write 0 to address 0, 1 to address 1, and 2 to address 2, each with a 1-cycle write_en; then read addresses 0, 1, 2 with out_en=1 -> data reads 0x00, 0x01, 0x02.
REQ-029 With out_en=0 and any address -> data is all-Z; with out_en=1 and write_en=1 while writing 0xA5 to address 3 -> no contention, and a later read of address 3 returns 0xA5.
REQ-030 Write 0xFF to address 15, then read address 15 and address 0 -> 0xFF and 0x00 respectively, with no aliasing.
REQ-031 Write 0x3C to address 5, pulse reset_n low between clock edges, then read address 5 -> 0x00, and the bus is Z during reset.
REQ-032 With RAM_PARITY_EN defined: write 0x0F to address 7, force a single bit flip in the stored word, then read address 7 -> parity_err=1; reading an unflipped word -> parity_err=0.

Source files
------------

// File: rtl/ram_pkg.sv
// Shared constants and parity helper for the ram block.
// Defaults here set the ram geometry when the instantiator gives no parameters.
// The parity function is used by ram_parity when RAM_PARITY_EN is defined.
package ram_pkg;

  localparam int DEF_ADDR_BITS = 4;
  localparam int DEF_DATA_BITS = 8;

  // Widest word the parity helper accepts; narrower words are zero-extended,
  // which leaves the XOR reduction unchanged.
  localparam int PAR_MAX_BITS = 64;

  // Even parity: the returned bit makes the total count of ones even.
  function automatic logic even_parity(input logic [PAR_MAX_BITS-1:0] v);
    return ^v;
  endfunction

endpackage

// File: rtl/ram_parity.sv
// Parity generate/check for the ram; built only when RAM_PARITY_EN is defined.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the error flag is qualified by the read enable.
module ram_parity
  import ram_pkg::*;
#(
  parameter int DATA_BITS = DEF_DATA_BITS
) (
  input  logic [DATA_BITS-1:0] i_wr_data,
  input  logic [DATA_BITS-1:0] i_rd_data,
  input  logic                 i_rd_par,
  input  logic                 i_rd_en,
  output logic                 o_wr_par,
  output logic                 o_err
);

  logic w_rd_par_calc;

  // Parity bit stored alongside each written word.
  assign o_wr_par = even_parity(PAR_MAX_BITS'(i_wr_data));

  // Recompute on the read path and flag a mismatch only while a read is active.
  assign w_rd_par_calc = even_parity(PAR_MAX_BITS'(i_rd_data));
  assign o_err         = i_rd_en & (i_rd_par ^ w_rd_par_calc);

endmodule

// File: rtl/ram.sv
// Single-port RAM on a shared bidirectional bus; optional RAM_PARITY_EN adds parity.
// Latency: writes commit on the rising clock edge; reads are combinational.
// Backpressure: none; write_en overrides out_en so the bus never sees contention.
module ram
  import ram_pkg::*;
#(
  parameter int ADDR_BITS = DEF_ADDR_BITS,
  parameter int DATA_BITS = DEF_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [ADDR_BITS-1:0] address,
  inout  wire  [DATA_BITS-1:0] data,
  input  logic                 out_en,
  input  logic                 write_en
`ifdef RAM_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [DATA_BITS-1:0] r_mem [DEPTH];
  logic [DATA_BITS-1:0] w_rd_word;
  logic                 w_rd_en;

  // The RAM owns the bus only for a plain read outside reset; a write wins.
  assign w_rd_en   = out_en & ~write_en & reset_n;
  assign w_rd_word = r_mem[address];

  // Sole driver of the shared bus.
  assign data = w_rd_en ? w_rd_word : {DATA_BITS{1'bz}};

  // Storage: cleared asynchronously by reset, bus value captured on write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (write_en) begin
      r_mem[address] <= data;
    end
  end

`ifdef RAM_PARITY_EN
  logic [DEPTH-1:0] r_par;
  logic             w_wr_par;

  ram_parity #(
    .DATA_BITS (DATA_BITS)
  ) u_parity (
    .i_wr_data (data),
    .i_rd_data (w_rd_word),
    .i_rd_par  (r_par[address]),
    .i_rd_en   (w_rd_en),
    .o_wr_par  (w_wr_par),
    .o_err     (parity_err)
  );

  // Parity bits track the data array; zero parity matches zeroed data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_par <= '0;
    end else if (write_en) begin
      r_par[address] <= w_wr_par;
    end
  end
`endif

endmodule

// File: tb/tb_ram.sv
module tb_ram;

  logic       clk;
  logic       reset_n;
  logic [3:0] address;
  wire  [7:0] data;
  logic       out_en;
  logic       write_en;
  logic [7:0] tb_dat;
  logic       tb_drv;
`ifdef RAM_PARITY_EN
  logic       parity_err;
`endif

  int checks;
  int failures;

  // External master driver on the shared bus.
  assign data = tb_drv ? tb_dat : 8'hzz;

  ram dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .address  (address),
    .data     (data),
    .out_en   (out_en),
    .write_en (write_en)
`ifdef RAM_PARITY_EN
    ,
    .parity_err (parity_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_write(input logic [3:0] a, input logic [7:0] d);
    @(negedge clk);
    address  = a;
    tb_dat   = d;
    tb_drv   = 1'b1;
    write_en = 1'b1;
    out_en   = 1'b0;
    @(negedge clk);
    write_en = 1'b0;
    tb_drv   = 1'b0;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    #12;
`ifdef RAM_PARITY_EN
    checks++;
    if (parity_err !== 1'b0) begin
      failures++;
      $display("FAIL reset_parity_err got=%b exp=0", parity_err);
    end
`endif
    @(negedge clk);
    reset_n = 1'b1;
    out_en  = 1'b1;
    address = 4'd0;
    #1;
    checks++;
    if (data !== 8'h00) begin
      failures++;
      $display("FAIL reset_addr0 got=%h exp=00", data);
    end
    address = 4'd5;
    #1;
    checks++;
    if (data !== 8'h00) begin
      failures++;
      $display("FAIL reset_addr5 got=%h exp=00", data);
    end
    address = 4'd15;
    #1;
    checks++;
    if (data !== 8'h00) begin
      failures++;
      $display("FAIL reset_addr15 got=%h exp=00", data);
    end
`ifdef RAM_PARITY_EN
    checks++;
    if (parity_err !== 1'b0) begin
      failures++;
      $display("FAIL post_reset_parity_err got=%b exp=0", parity_err);
    end
`endif
    out_en = 1'b0;
  endtask

  task automatic test_write_read;
    logic [7:0] exp [3];
    exp[0] = 8'h00;
    exp[1] = 8'h01;
    exp[2] = 8'h02;
    do_write(4'd0, 8'h00);
    do_write(4'd1, 8'h01);
    do_write(4'd2, 8'h02);
    out_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      address = 4'(i);
      #1;
      checks++;
      if (data !== exp[i]) begin
        failures++;
        $display("FAIL read_addr%0d got=%h exp=%h", i, data, exp[i]);
      end
    end
    out_en = 1'b0;
  endtask

  task automatic test_tristate;
    // out_en low: probe with 0x00 at a word holding 0x01; any RAM drive shows up.
    @(negedge clk);
    address = 4'd1;
    out_en  = 1'b0;
    tb_dat  = 8'h00;
    tb_drv  = 1'b1;
    #1;
    checks++;
    if (data !== 8'h00) begin
      failures++;
      $display("FAIL out_en_low_bus got=%h exp=00", data);
    end
    tb_drv = 1'b0;
    do_write(4'd3, 8'h5A);
    // Both enables high: bus must carry only the master's 0xA5.
    @(negedge clk);
    address  = 4'd3;
    tb_dat   = 8'hA5;
    tb_drv   = 1'b1;
    out_en   = 1'b1;
    write_en = 1'b1;
    #1;
    checks++;
    if (data !== 8'hA5) begin
      failures++;
      $display("FAIL contention_bus got=%h exp=a5", data);
    end
    @(negedge clk);
    write_en = 1'b0;
    tb_drv   = 1'b0;
    #1;
    checks++;
    if (data !== 8'hA5) begin
      failures++;
      $display("FAIL readback_addr3 got=%h exp=a5", data);
    end
    out_en = 1'b0;
  endtask

  task automatic test_boundary;
    do_write(4'd15, 8'hFF);
    out_en  = 1'b1;
    address = 4'd15;
    #1;
    checks++;
    if (data !== 8'hFF) begin
      failures++;
      $display("FAIL read_addr15 got=%h exp=ff", data);
    end
    address = 4'd0;
    #1;
    checks++;
    if (data !== 8'h00) begin
      failures++;
      $display("FAIL alias_addr0 got=%h exp=00", data);
    end
    out_en = 1'b0;
  endtask

  task automatic test_addr_change_write;
    // Address moves from 8 to 9 before the edge: only word 9 is written.
    @(negedge clk);
    address  = 4'd8;
    tb_dat   = 8'h11;
    tb_drv   = 1'b1;
    write_en = 1'b1;
    #3;
    address = 4'd9;
    @(negedge clk);
    write_en = 1'b0;
    tb_drv   = 1'b0;
    out_en   = 1'b1;
    address  = 4'd9;
    #1;
    checks++;
    if (data !== 8'h11) begin
      failures++;
      $display("FAIL addr_change_word9 got=%h exp=11", data);
    end
    address = 4'd8;
    #1;
    checks++;
    if (data !== 8'h00) begin
      failures++;
      $display("FAIL addr_change_word8 got=%h exp=00", data);
    end
    out_en = 1'b0;
  endtask

  task automatic test_reset_mid;
    do_write(4'd5, 8'h3C);
    // Reset pulse wholly between two rising edges.
    @(negedge clk);
    address = 4'd5;
    out_en  = 1'b1;
    #1;
    reset_n = 1'b0;
    tb_dat  = 8'h3C;
    tb_drv  = 1'b1;
    #1;
    checks++;
    if (data !== 8'h3C) begin
      failures++;
      $display("FAIL reset_bus_probe got=%h exp=3c", data);
    end
    tb_drv = 1'b0;
    #1;
    reset_n = 1'b1;
    #1;
    checks++;
    if (data !== 8'h00) begin
      failures++;
      $display("FAIL reset_clear_addr5 got=%h exp=00", data);
    end
    out_en = 1'b0;
    // Reset held across the write edge: write aborted.
    @(negedge clk);
    address  = 4'd6;
    tb_dat   = 8'h77;
    tb_drv   = 1'b1;
    write_en = 1'b1;
    #2;
    reset_n = 1'b0;
    @(negedge clk);
    write_en = 1'b0;
    tb_drv   = 1'b0;
    reset_n  = 1'b1;
    out_en   = 1'b1;
    #1;
    checks++;
    if (data !== 8'h00) begin
      failures++;
      $display("FAIL aborted_write_addr6 got=%h exp=00", data);
    end
    // First edge after release performs a write.
    out_en   = 1'b0;
    address  = 4'd10;
    tb_dat   = 8'h42;
    tb_drv   = 1'b1;
    write_en = 1'b1;
    @(negedge clk);
    write_en = 1'b0;
    tb_drv   = 1'b0;
    out_en   = 1'b1;
    #1;
    checks++;
    if (data !== 8'h42) begin
      failures++;
      $display("FAIL first_edge_write got=%h exp=42", data);
    end
    out_en = 1'b0;
  endtask

`ifdef RAM_PARITY_EN
  task automatic test_parity;
    do_write(4'd7, 8'h0F);
    out_en  = 1'b1;
    address = 4'd7;
    #1;
    checks++;
    if (parity_err !== 1'b0) begin
      failures++;
      $display("FAIL parity_clean got=%b exp=0", parity_err);
    end
    out_en = 1'b0;
    @(negedge clk);
    dut.r_mem[7] = 8'h0E;
    out_en  = 1'b1;
    #1;
    checks++;
    if (parity_err !== 1'b1) begin
      failures++;
      $display("FAIL parity_flip got=%b exp=1", parity_err);
    end
    address = 4'd10;
    #1;
    checks++;
    if (parity_err !== 1'b0) begin
      failures++;
      $display("FAIL parity_other_word got=%b exp=0", parity_err);
    end
    out_en = 1'b0;
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    address  = '0;
    out_en   = 1'b0;
    write_en = 1'b0;
    tb_dat   = '0;
    tb_drv   = 1'b0;
    test_reset();
    test_write_read();
    test_tristate();
    test_boundary();
    test_addr_change_write();
    test_reset_mid();
`ifdef RAM_PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
